// File: rtl/wb_stage_if.sv
// Writeback stage bus: stage-2 results, dcache load return,
// register-file write port, stage-1 bypass and retire counter.
interface wb_stage_if #(
   parameter int INSTRET_W = 64
);
   logic                 stall;
   logic                 s2_valid;
   logic [4:0]           s2_rd;
   logic                 s2_we;
   logic [1:0]           s2_wb_sel;
   logic [2:0]           s2_funct3;
   logic [31:0]          s2_alu_out;
   logic [31:0]          s2_pc_plus4;
   logic [31:0]          dcache_dout;
   logic                 dcache_valid;
   logic [4:0]           wb_rd;
   logic [31:0]          wb_data;
   logic                 wb_we;
   logic                 fwd_valid;
   logic [4:0]           fwd_rd;
   logic [31:0]          fwd_data;
   logic                 stall_req;
   logic [INSTRET_W-1:0] instret;

   modport master (
      output stall, s2_valid, s2_rd, s2_we, s2_wb_sel,
      output s2_funct3, s2_alu_out, s2_pc_plus4,
      output dcache_dout, dcache_valid,
      input  wb_rd, wb_data, wb_we,
      input  fwd_valid, fwd_rd, fwd_data,
      input  stall_req, instret
   );

   modport slave (
      input  stall, s2_valid, s2_rd, s2_we, s2_wb_sel,
      input  s2_funct3, s2_alu_out, s2_pc_plus4,
      input  dcache_dout, dcache_valid,
      output wb_rd, wb_data, wb_we,
      output fwd_valid, fwd_rd, fwd_data,
      output stall_req, instret
   );
endinterface

// File: rtl/wb_stage.sv
// Stage 3 writeback: load wait/align, stalled-load capture,
// register-file write, stage-1 bypass and retired-instruction count.
module wb_stage #(
   parameter int INSTRET_W = 64
) (
   input logic     clk,
   input logic     reset,
   wb_stage_if.slave bus
);
   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      MEM_HELD
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_valid;
   logic [4:0]           r_rd;
   logic                 r_we;
   logic [1:0]           r_wb_sel;
   logic [2:0]           r_funct3;
   logic [31:0]          r_alu;
   logic [31:0]          r_pc4;
   logic [31:0]          r_hold;
   logic [INSTRET_W-1:0] r_instret;

   logic        w_is_load;
   logic        w_held;
   logic        w_stall_req;
   logic        w_advance;
   logic        w_data_ready;
   logic        w_retire;
   logic        w_capture;
   logic        w_wr;
   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_data;

   assign w_is_load    = r_valid & (r_wb_sel == 2'd1);
   assign w_held       = (r_state == MEM_HELD);
   assign w_stall_req  = w_is_load & !w_held & !bus.dcache_valid;
   assign w_advance    = !bus.stall & !w_stall_req;
   assign w_data_ready = !w_is_load | bus.dcache_valid | w_held;
   assign w_retire     = r_valid & w_data_ready & !bus.stall;
   assign w_wr         = r_we & (r_rd != 5'd0);
   assign w_capture    = w_is_load & !w_held
                       & bus.dcache_valid & bus.stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid  <= 1'b0;
         r_rd     <= '0;
         r_we     <= 1'b0;
         r_wb_sel <= '0;
         r_funct3 <= '0;
         r_alu    <= '0;
         r_pc4    <= '0;
      end else if (w_advance) begin
         r_valid  <= bus.s2_valid;
         r_rd     <= bus.s2_rd;
         r_we     <= bus.s2_we;
         r_wb_sel <= bus.s2_wb_sel;
         r_funct3 <= bus.s2_funct3;
         r_alu    <= bus.s2_alu_out;
         r_pc4    <= bus.s2_pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= RUN;
         r_hold    <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture)
            r_hold <= bus.dcache_dout;
         if (w_retire)
            r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RUN, MEM_WAIT: begin
            w_next = RUN;
            if (w_is_load) begin
               if (!bus.dcache_valid)
                  w_next = MEM_WAIT;
               else if (bus.stall)
                  w_next = MEM_HELD;
            end
         end
         MEM_HELD: begin
            if (!bus.stall)
               w_next = RUN;
         end
         default: w_next = RUN;
      endcase
   end

   assign w_word = w_held ? r_hold : bus.dcache_dout;
   assign w_half = r_alu[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_byte = w_word[7:0];
      unique case (r_alu[1:0])
         2'd0: w_byte = w_word[7:0];
         2'd1: w_byte = w_word[15:8];
         2'd2: w_byte = w_word[23:16];
         2'd3: w_byte = w_word[31:24];
         default: w_byte = w_word[7:0];
      endcase
   end

   always_comb begin
      w_load = w_word;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = w_word;
      endcase
   end

   always_comb begin
      w_data = r_alu;
      case (r_wb_sel)
         2'd1:    w_data = w_load;
         2'd2:    w_data = r_pc4;
         default: w_data = r_alu;
      endcase
   end

   assign bus.wb_rd     = r_rd;
   assign bus.wb_data   = w_data;
   assign bus.wb_we     = w_retire & w_wr;
   // Bypass ignores stall so a held consumer still sees the value.
   assign bus.fwd_valid = r_valid & w_data_ready & w_wr;
   assign bus.fwd_rd    = r_rd;
   assign bus.fwd_data  = w_data;
   assign bus.stall_req = w_stall_req;
   assign bus.instret   = r_instret;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, scoreboard of
// expected register-file writes, and hand-written stall sequences.
module tb_wb_stage;
   localparam int IW = 64;

   logic clk;
   logic rst_n;

   wb_stage_if #(.INSTRET_W(IW)) bus ();

   wb_stage #(.INSTRET_W(IW)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [37:0] wdata_pad;
   } dummy_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [1:0]  sel;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] dout;
      logic        exp_we;
      logic [31:0] exp_data;
   } vec_t;

   int  total = 0;
   int  bad   = 0;
   wr_t sb[$];
   longint unsigned n_ret = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.wb_we !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {59'd0, bus.wb_rd}, 64'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("sb_rd", {59'd0, bus.wb_rd}, {59'd0, e.rd});
            chk("sb_data", {32'd0, bus.wb_data}, {32'd0, e.data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic we,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4);
      bus.s2_valid    = 1'b1;
      bus.s2_rd       = rd;
      bus.s2_we       = we;
      bus.s2_wb_sel   = sel;
      bus.s2_funct3   = f3;
      bus.s2_alu_out  = alu;
      bus.s2_pc_plus4 = pc4;
      bus.dcache_valid = 1'b0;
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] d);
      wr_t e;
      e.rd   = rd;
      e.data = d;
      sb.push_back(e);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{5'd5, 1'b1, 2'd0, 3'd0, 32'h0000_1234, 32'h0,
                   32'h0, 1'b1, 32'h0000_1234};
      vecs[1]  = '{5'd6, 1'b1, 2'd1, 3'b000, 32'h0000_1002, 32'h0,
                   32'h0080_0000, 1'b1, 32'hFFFF_FF80};
      vecs[2]  = '{5'd6, 1'b1, 2'd1, 3'b100, 32'h0000_1002, 32'h0,
                   32'h0080_0000, 1'b1, 32'h0000_0080};
      vecs[3]  = '{5'd7, 1'b1, 2'd1, 3'b101, 32'h0000_2002, 32'h0,
                   32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
      vecs[4]  = '{5'd8, 1'b1, 2'd1, 3'b001, 32'h0000_0000, 32'h0,
                   32'h1234_8001, 1'b1, 32'hFFFF_8001};
      vecs[5]  = '{5'd9, 1'b1, 2'd1, 3'b010, 32'h0000_0003, 32'h0,
                   32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vecs[6]  = '{5'd10, 1'b1, 2'd1, 3'b000, 32'h0000_0003, 32'h0,
                   32'h7F00_0000, 1'b1, 32'h0000_007F};
      vecs[7]  = '{5'd11, 1'b1, 2'd2, 3'd0, 32'h0000_00AA, 32'h100,
                   32'h0, 1'b1, 32'h0000_0100};
      vecs[8]  = '{5'd12, 1'b1, 2'd3, 3'd0, 32'h0000_0055, 32'h200,
                   32'h0, 1'b1, 32'h0000_0055};
      vecs[9]  = '{5'd0, 1'b1, 2'd0, 3'd0, 32'h0000_9999, 32'h0,
                   32'h0, 1'b0, 32'h0000_9999};
      vecs[10] = '{5'd13, 1'b0, 2'd0, 3'd0, 32'h0000_4444, 32'h0,
                   32'h0, 1'b0, 32'h0000_4444};
      vecs[11] = '{5'd14, 1'b1, 2'd1, 3'b011, 32'h0000_0001, 32'h0,
                   32'h1122_3344, 1'b1, 32'h1122_3344};

      rst_n = 1'b0;
      bus.stall = 1'b0;
      bus.s2_valid = 1'b0;
      bus.s2_rd = '0;
      bus.s2_we = 1'b0;
      bus.s2_wb_sel = '0;
      bus.s2_funct3 = '0;
      bus.s2_alu_out = '0;
      bus.s2_pc_plus4 = '0;
      bus.dcache_dout = '0;
      bus.dcache_valid = 1'b0;

      #2;
      chk("rst_wb_we", {63'd0, bus.wb_we}, 64'd0);
      chk("rst_fwd_valid", {63'd0, bus.fwd_valid}, 64'd0);
      chk("rst_stall_req", {63'd0, bus.stall_req}, 64'd0);
      chk("rst_wb_data", {32'd0, bus.wb_data}, 64'd0);
      chk("rst_instret", bus.instret, 64'd0);

      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].rd, vecs[i].we, vecs[i].sel, vecs[i].f3,
               vecs[i].alu, vecs[i].pc4);
         tick();
         bus.s2_valid     = 1'b0;
         bus.dcache_valid = (vecs[i].sel == 2'd1);
         bus.dcache_dout  = vecs[i].dout;
         if (vecs[i].exp_we)
            push(vecs[i].rd, vecs[i].exp_data);
         @(negedge clk);
         chk($sformatf("v%0d_wb_we", i), {63'd0, bus.wb_we},
             {63'd0, vecs[i].exp_we});
         chk($sformatf("v%0d_fwd_valid", i), {63'd0, bus.fwd_valid},
             {63'd0, vecs[i].exp_we});
         chk($sformatf("v%0d_fwd_data", i), {32'd0, bus.fwd_data},
             {32'd0, vecs[i].exp_data});
         chk($sformatf("v%0d_stall_req", i), {63'd0, bus.stall_req}, 64'd0);
         chk($sformatf("v%0d_instret", i), bus.instret, n_ret);
         n_ret++;
         tick();
         bus.dcache_valid = 1'b0;
      end
      tick();
      chk("bubble_instret", bus.instret, n_ret);

      // Load waiting three cycles; younger ALU op must stay in stage 2.
      issue(5'd15, 1'b1, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      issue(5'd16, 1'b1, 2'd0, 3'd0, 32'h0000_0077, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("wait%0d_stall_req", c), {63'd0, bus.stall_req}, 64'd1);
         chk($sformatf("wait%0d_fwd_valid", c), {63'd0, bus.fwd_valid}, 64'd0);
         chk($sformatf("wait%0d_wb_rd", c), {59'd0, bus.wb_rd}, 64'd15);
         tick();
      end
      bus.dcache_valid = 1'b1;
      bus.dcache_dout  = 32'hCAFE_F00D;
      push(5'd15, 32'hCAFE_F00D);
      @(negedge clk);
      chk("wait_done_stall_req", {63'd0, bus.stall_req}, 64'd0);
      chk("wait_done_wb_we", {63'd0, bus.wb_we}, 64'd1);
      tick();
      bus.s2_valid = 1'b0;
      bus.dcache_valid = 1'b0;
      push(5'd16, 32'h0000_0077);
      @(negedge clk);
      chk("after_wait_wb_we", {63'd0, bus.wb_we}, 64'd1);
      n_ret += 2;
      tick();

      // Load data arrives under stall, then dcache output changes.
      issue(5'd17, 1'b1, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      bus.s2_valid = 1'b0;
      bus.stall = 1'b1;
      bus.dcache_valid = 1'b1;
      bus.dcache_dout = 32'hA5A5_A5A5;
      @(negedge clk);
      chk("held0_wb_we", {63'd0, bus.wb_we}, 64'd0);
      chk("held0_fwd_valid", {63'd0, bus.fwd_valid}, 64'd1);
      tick();
      bus.dcache_dout = 32'h0;
      @(negedge clk);
      chk("held1_wb_we", {63'd0, bus.wb_we}, 64'd0);
      chk("held1_stall_req", {63'd0, bus.stall_req}, 64'd0);
      chk("held1_fwd_data", {32'd0, bus.fwd_data}, 64'hA5A5_A5A5);
      tick();
      bus.dcache_valid = 1'b0;
      @(negedge clk);
      chk("held2_stall_req", {63'd0, bus.stall_req}, 64'd0);
      chk("held2_instret", bus.instret, n_ret);
      tick();
      bus.stall = 1'b0;
      push(5'd17, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("held_rel_wb_we", {63'd0, bus.wb_we}, 64'd1);
      n_ret++;
      tick();
      @(negedge clk);
      chk("held_instret", bus.instret, n_ret);

      // Reset while a load waits in MEM_WAIT.
      tick();
      issue(5'd18, 1'b1, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      bus.s2_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_stall_req", {63'd0, bus.stall_req}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wb_we", {63'd0, bus.wb_we}, 64'd0);
      chk("async_rst_stall_req", {63'd0, bus.stall_req}, 64'd0);
      chk("async_rst_instret", bus.instret, 64'd0);
      tick();
      rst_n = 1'b1;
      bus.dcache_valid = 1'b1;
      bus.dcache_dout = 32'h0000_FFFF;
      @(negedge clk);
      chk("post_rst_wb_we", {63'd0, bus.wb_we}, 64'd0);
      chk("post_rst_stall_req", {63'd0, bus.stall_req}, 64'd0);
      tick();
      bus.dcache_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_instret", bus.instret, 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
